// File: rtl/spi_master_core.sv
// spi_master_core: SPI master engine that serialises one 8/16/24/32-bit word per start
// with programmable mode, SCK rate and CS lead/trail/inter-frame gaps.
module spi_master_core (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start_in,
    input  logic [1:0]  spi_mode_in,
    input  logic [1:0]  sck_speed_in,
    input  logic [1:0]  word_len_in,
    input  logic [7:0]  IFG_in,
    input  logic [7:0]  CS_SCK_in,
    input  logic [7:0]  SCK_CS_in,
    input  logic [31:0] mosi_data_in,
    output logic        busy_out,
    output logic [31:0] miso_data_out,
    output logic        sck_out,
    output logic        mosi_out,
    output logic        cs_out,
    input  logic        miso_in
);
    localparam logic [2:0] IDLE = 3'd0, LEAD = 3'd1, XFER = 3'd2, TRAIL = 3'd3, GAP = 3'd4;
    logic [2:0]  state_q, state_d, h_q, h_d, h_in, h_lat, after_trail, after_xfer;
    logic [7:0]  cnt_q, cnt_d, sck_cs_q, sck_cs_d, ifg_q, ifg_d;
    logic [5:0]  edge_q, edge_d;
    logic [1:0]  spd_q, spd_d, wl_q, wl_d;
    logic [31:0] tx_q, tx_d, rx_q, rx_d, miso_q, miso_d, aligned;
    logic        cpha_q, cpha_d, sck_q, sck_d, mosi_q, mosi_d, busy_q, cs_q, lead, last;
    // Transmit word is left-aligned so the current bit is always tx_q[31].
    assign aligned     = mosi_data_in << {~word_len_in, 3'b000};
    assign h_in        = 3'((4'd1 << sck_speed_in) - 4'd1);
    assign h_lat       = 3'((4'd1 << spd_q) - 4'd1);
    assign lead        = ~edge_q[0];
    assign last        = edge_q == {wl_q, 4'hF};
    assign after_trail = ifg_q != 8'd0 ? GAP : IDLE;
    assign after_xfer  = sck_cs_q != 8'd0 ? TRAIL : after_trail;
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        h_d      = h_q;
        edge_d   = edge_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        miso_d   = miso_q;
        sck_d    = sck_q;
        mosi_d   = mosi_q;
        cpha_d   = cpha_q;
        spd_d    = spd_q;
        wl_d     = wl_q;
        ifg_d    = ifg_q;
        sck_cs_d = sck_cs_q;
        case (state_q)
            IDLE: if (start_in) begin
                cpha_d   = spi_mode_in[0];
                spd_d    = sck_speed_in;
                wl_d     = word_len_in;
                ifg_d    = IFG_in;
                sck_cs_d = SCK_CS_in;
                cnt_d    = CS_SCK_in;
                h_d      = h_in;
                edge_d   = 6'd0;
                tx_d     = aligned;
                rx_d     = 32'd0;
                sck_d    = spi_mode_in[1];
                mosi_d   = aligned[31];
                state_d  = CS_SCK_in != 8'd0 ? LEAD : XFER;
            end
            LEAD: if (cnt_q == 8'd1) state_d = XFER; else cnt_d = cnt_q - 8'd1;
            XFER: if (h_q != 3'd0) h_d = h_q - 3'd1; else begin
                h_d    = h_lat;
                sck_d  = ~sck_q;
                edge_d = edge_q + 6'd1;
                if (lead ^ cpha_q) rx_d = (rx_q << 1) | 32'(miso_in);
                if (lead == cpha_q && !last) begin
                    mosi_d = cpha_q ? tx_q[31] : tx_q[30];
                    tx_d   = tx_q << 1;
                end
                if (last) begin
                    state_d = after_xfer;
                    miso_d  = rx_d;
                    cnt_d   = sck_cs_q != 8'd0 ? sck_cs_q : ifg_q;
                end
            end
            TRAIL: if (cnt_q == 8'd1) begin
                state_d = after_trail;
                cnt_d   = ifg_q;
            end else cnt_d = cnt_q - 8'd1;
            GAP: if (cnt_q == 8'd1) state_d = IDLE; else cnt_d = cnt_q - 8'd1;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            h_q      <= 3'd0;
            edge_q   <= 6'd0;
            tx_q     <= 32'd0;
            rx_q     <= 32'd0;
            miso_q   <= 32'd0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            cpha_q   <= 1'b0;
            spd_q    <= 2'd0;
            wl_q     <= 2'd0;
            ifg_q    <= 8'd0;
            sck_cs_q <= 8'd0;
            busy_q   <= 1'b0;
            cs_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            h_q      <= h_d;
            edge_q   <= edge_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            miso_q   <= miso_d;
            sck_q    <= sck_d;
            mosi_q   <= mosi_d;
            cpha_q   <= cpha_d;
            spd_q    <= spd_d;
            wl_q     <= wl_d;
            ifg_q    <= ifg_d;
            sck_cs_q <= sck_cs_d;
            busy_q   <= state_d != IDLE;
            cs_q     <= state_d == GAP || state_d == IDLE;
        end
    end
    assign busy_out      = busy_q;
    assign cs_out        = cs_q;
    assign sck_out       = sck_q;
    assign mosi_out      = mosi_q;
    assign miso_data_out = miso_q;
endmodule

// File: tb/tb_spi_master_core.sv
// tb_spi_master_core: directed frames checked every cycle against a timeline model
// of the SPI frame, plus hand-computed per-frame totals.
module tb_spi_master_core;
    logic        clk = 1'b0, rst_n = 1'b0, start_in = 1'b0;
    logic [1:0]  spi_mode_in = 2'd0, sck_speed_in = 2'd0, word_len_in = 2'd0;
    logic [7:0]  IFG_in = 8'd0, CS_SCK_in = 8'd0, SCK_CS_in = 8'd0;
    logic [31:0] mosi_data_in = 32'd0, miso_data_out;
    logic        busy_out, sck_out, mosi_out, cs_out, miso_in;
    bit          lp = 1'b0, tv = 1'b0;
    int          n_chk = 0, n_fail = 0;
    assign miso_in = lp ? mosi_out : tv;
    always #5 clk = ~clk;
    spi_master_core dut (
        .CLK(clk), .RST(rst_n), .start_in(start_in), .spi_mode_in(spi_mode_in),
        .sck_speed_in(sck_speed_in), .word_len_in(word_len_in), .IFG_in(IFG_in),
        .CS_SCK_in(CS_SCK_in), .SCK_CS_in(SCK_CS_in), .mosi_data_in(mosi_data_in),
        .busy_out(busy_out), .miso_data_out(miso_data_out), .sck_out(sck_out),
        .mosi_out(mosi_out), .cs_out(cs_out), .miso_in(miso_in)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // Model: every output is a function of cycles elapsed since the frame was accepted.
    bit          act = 1'b0, cpol, cpha;
    int          t = 0, L = 0, X = 0, Tr = 0, G = 0, H = 1, len = 8, e, s;
    logic [31:0] data, word, mask, e_miso = 32'd0;
    logic        e_busy = 1'b0, e_cs = 1'b1, e_sck = 1'b0, e_mosi = 1'b0;
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            act = 1'b0; e_busy = 1'b0; e_cs = 1'b1; e_sck = 1'b0; e_mosi = 1'b0; e_miso = 32'd0;
        end else begin
            if (act) t++;
            if (start_in && (!act || t > L + X + Tr + G)) begin
                act = 1'b1; t = 0;
                L = CS_SCK_in; Tr = SCK_CS_in; G = IFG_in;
                H = 1 << sck_speed_in; len = 8 * (word_len_in + 1); X = 2 * len * H;
                cpol = spi_mode_in[1]; cpha = spi_mode_in[0];
                mask = len == 32 ? 32'hFFFF_FFFF : (32'd1 << len) - 32'd1;
                data = mosi_data_in & mask;
                word = lp ? data : (tv ? mask : 32'd0);
            end
            if (act) begin
                e = t < L ? 0 : (t - L) / H;
                if (e > 2 * len) e = 2 * len;
                e_busy = t < L + X + Tr + G;
                e_cs   = t >= L + X + Tr;
                e_sck  = cpol ^ e[0];
                s = cpha ? ((e + 1) / 2 > 0 ? (e + 1) / 2 - 1 : 0) : (e / 2 > len - 1 ? len - 1 : e / 2);
                e_mosi = data[len - 1 - s];
                if (t == L + X) e_miso = word;
            end
        end
    end
    always @(negedge clk) begin
        chk("busy_out", 32'(busy_out), 32'(e_busy));
        chk("cs_out", 32'(cs_out), 32'(e_cs));
        chk("sck_out", 32'(sck_out), 32'(e_sck));
        chk("mosi_out", 32'(mosi_out), 32'(e_mosi));
        chk("miso_data_out", miso_data_out, e_miso);
    end
    task automatic frame(input logic [1:0] m, input logic [1:0] sp, input logic [1:0] wl,
                         input logic [7:0] ld, input logic [7:0] tr, input logic [7:0] gp,
                         input logic [31:0] d, input bit l, input bit tie,
                         output int nb, output int nc, output int nr, output logic [31:0] bits);
        logic ps;
        @(negedge clk);
        spi_mode_in = m; sck_speed_in = sp; word_len_in = wl;
        CS_SCK_in = ld; SCK_CS_in = tr; IFG_in = gp; mosi_data_in = d;
        lp = l; tv = tie; start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        nb = 0; nc = 0; nr = 0; bits = 32'd0; ps = sck_out;
        while (busy_out && nb < 1000) begin
            nb++;
            if (!cs_out) nc++;
            if (sck_out && !ps) begin
                nr++;
                bits = {bits[30:0], mosi_out};
            end
            ps = sck_out;
            @(negedge clk);
        end
        chk("frame_ends_in_bound", 32'(nb < 1000), 32'd1);
    endtask
    int          nb, nc, nr, n;
    logic [31:0] bits;
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_cs", 32'(cs_out), 32'd1);
        chk("rst_sck", 32'(sck_out), 32'd0);
        chk("rst_mosi", 32'(mosi_out), 32'd0);
        chk("rst_miso", miso_data_out, 32'd0);
        rst_n = 1'b1;
        frame(2'd0, 2'd0, 2'd0, 8'd2, 8'd3, 8'd4, 32'hA5, 1'b1, 1'b0, nb, nc, nr, bits);
        chk("m0_busy_cycles", nb, 25);
        chk("m0_cs_low_cycles", nc, 21);
        chk("m0_sck_pulses", nr, 8);
        chk("m0_mosi_bits", bits, 32'hA5);
        chk("m0_miso", miso_data_out, 32'h0000_00A5);
        frame(2'd3, 2'd2, 2'd3, 8'd1, 8'd2, 8'd3, 32'hDEAD_BEEF, 1'b1, 1'b0, nb, nc, nr, bits);
        chk("m3_busy_cycles", nb, 262);
        chk("m3_cs_low_cycles", nc, 259);
        chk("m3_sck_pulses", nr, 32);
        chk("m3_miso", miso_data_out, 32'hDEAD_BEEF);
        chk("m3_sck_idle_high", 32'(sck_out), 32'd1);
        frame(2'd1, 2'd1, 2'd1, 8'd0, 8'd0, 8'd0, 32'h5A3C, 1'b0, 1'b1, nb, nc, nr, bits);
        chk("m1_busy_cycles", nb, 64);
        chk("m1_sck_pulses", nr, 16);
        chk("m1_mosi_bits", bits, 32'h5A3C);
        chk("m1_miso", miso_data_out, 32'h0000_FFFF);
        // Start re-pulsed with new config mid-frame must be ignored.
        @(negedge clk);
        spi_mode_in = 2'd0; sck_speed_in = 2'd0; word_len_in = 2'd0;
        CS_SCK_in = 8'd2; SCK_CS_in = 8'd2; IFG_in = 8'd2; mosi_data_in = 32'h3C;
        lp = 1'b1; tv = 1'b0; start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        repeat (4) @(negedge clk);
        mosi_data_in = 32'hFFFF_FFFF; word_len_in = 2'd3; spi_mode_in = 2'd3; start_in = 1'b1;
        repeat (3) @(negedge clk);
        start_in = 1'b0;
        n = 0;
        while (busy_out && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("ign_frame_ends", 32'(n < 200), 32'd1);
        chk("ign_miso", miso_data_out, 32'h0000_003C);
        repeat (6) begin
            @(negedge clk);
            chk("ign_no_second_frame", 32'(busy_out), 32'd0);
        end
        // Reset in the middle of XFER, around bit 5.
        @(negedge clk);
        spi_mode_in = 2'd0; sck_speed_in = 2'd0; word_len_in = 2'd0;
        CS_SCK_in = 8'd2; SCK_CS_in = 8'd1; IFG_in = 8'd1; mosi_data_in = 32'h96;
        lp = 1'b1; start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        repeat (11) @(negedge clk);
        chk("pre_rst_busy", 32'(busy_out), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cs", 32'(cs_out), 32'd1);
        chk("abort_busy", 32'(busy_out), 32'd0);
        chk("abort_sck", 32'(sck_out), 32'd0);
        chk("abort_miso", miso_data_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        frame(2'd0, 2'd0, 2'd0, 8'd1, 8'd1, 8'd1, 32'h96, 1'b1, 1'b0, nb, nc, nr, bits);
        chk("post_rst_busy_cycles", nb, 19);
        chk("post_rst_miso", miso_data_out, 32'h0000_0096);
        frame(2'd2, 2'd0, 2'd2, 8'd1, 8'd1, 8'd1, 32'hFF12_3456, 1'b1, 1'b0, nb, nc, nr, bits);
        chk("m2_busy_cycles", nb, 51);
        chk("m2_sck_pulses", nr, 24);
        chk("m2_miso", miso_data_out, 32'h0012_3456);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
